// File: rtl/spi_ctrl_multi_if.sv
// Register-bus interface for spi_ctrl_multi: the bus agent drives the master
// modport, the SPI controller consumes the slave modport.
interface spi_ctrl_multi_if;
    logic [2:0]  addr;
    logic        we;
    logic [31:0] write_data;
    logic        re;
    logic [31:0] read_data;

    modport master (output addr, we, write_data, re, input read_data);
    modport slave  (input addr, we, write_data, re, output read_data);
endinterface

// File: rtl/spi_ctrl_multi.sv
// Register-mapped SPI master: CPOL/CPHA modes, SCK divider, multiple chip selects,
// optional address phase. Define SPI_CTRL_IRQ_EN to enable the done interrupt.
module spi_ctrl_multi #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 24,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_ctrl_multi_if.slave   bus,
    output logic              sck,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso,
    output logic              irq
);
    localparam int MAX_N = 8 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(MAX_N + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state_q, state_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, addr_en_q, addr_en_d;
    logic [2:0]        cs_sel_q, cs_sel_d;
    logic [DIV_W-1:0]  clkdiv_q, clkdiv_d, div_q, div_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d, dout_q, dout_d, rx_q, rx_d;
    logic              done_q, done_d, err_q, err_d, irq_en_q, irq_en_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, n_q, n_d;
    logic              phase_q, phase_d;
    logic [MAX_N-1:0]  tx_q, tx_d;
    logic              sck_q, sck_d, mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [31:0]       rdata_q, rdata_d;

    logic       busy, tick, cfg_wr, start, sample;
    logic [2:0] start_sel;

    assign busy      = (state_q != IDLE);
    assign tick      = (div_q == clkdiv_q);
    assign cfg_wr    = bus.we && !busy;
    assign start_sel = bus.write_data[6:4];
    assign start     = cfg_wr && (bus.addr == 3'd0) && bus.write_data[0];
    // phase_q=0 marks a leading edge; CPHA=0 samples there, CPHA=1 on the trailing one
    assign sample    = (phase_q == cpha_q);

    always_comb begin
        rdata_d = rdata_q;
        if (bus.re) begin
            case (bus.addr)
                3'd0:    rdata_d = {25'd0, cs_sel_q, addr_en_q, cpha_q, cpol_q, 1'b0};
                3'd1:    rdata_d = 32'(clkdiv_q);
                3'd2:    rdata_d = 32'(cmd_q);
                3'd3:    rdata_d = 32'(addr_q);
                3'd4:    rdata_d = 32'(din_q);
                3'd5:    rdata_d = 32'(dout_q);
                3'd6:    rdata_d = {28'd0, irq_en_q, err_q, done_q, busy};
                default: rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        addr_en_d = addr_en_q;
        cs_sel_d  = cs_sel_q;
        clkdiv_d  = clkdiv_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        din_d     = din_q;
        dout_d    = dout_q;
        done_d    = done_q;
        err_d     = err_q;
        irq_en_d  = irq_en_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        n_d       = n_q;
        phase_d   = phase_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;

        if (cfg_wr) begin
            case (bus.addr)
                3'd0: begin
                    cpol_d    = bus.write_data[1];
                    cpha_d    = bus.write_data[2];
                    addr_en_d = bus.write_data[3];
                    cs_sel_d  = bus.write_data[6:4];
                end
                3'd1:    clkdiv_d = bus.write_data[DIV_W-1:0];
                3'd2:    cmd_d    = bus.write_data[7:0];
                3'd3:    addr_d   = bus.write_data[ADDR_W-1:0];
                3'd4:    din_d    = bus.write_data[DATA_W-1:0];
                default: ;
            endcase
        end

        if (bus.we && bus.addr == 3'd6) begin
            if (bus.write_data[1]) done_d = 1'b0;
            if (bus.write_data[2]) err_d  = 1'b0;
`ifdef SPI_CTRL_IRQ_EN
            irq_en_d = bus.write_data[3];
`else
            irq_en_d = 1'b0;
`endif
        end

        case (state_q)
            IDLE: begin
                sck_d  = cpol_d;
                cs_n_d = '1;
                if (start) begin
                    if ({29'd0, start_sel} < NUM_CS) begin
                        state_d   = SETUP;
                        div_d     = '0;
                        bit_cnt_d = '0;
                        phase_d   = 1'b0;
                        rx_d      = '0;
                        n_d       = bus.write_data[3] ? CNT_W'(MAX_N) : CNT_W'(8 + DATA_W);
                        tx_d      = bus.write_data[3] ? {cmd_q, addr_q, din_q}
                                                      : {cmd_q, din_q, {ADDR_W{1'b0}}};
                        mosi_d    = cmd_q[7];
                        cs_n_d    = ~(NUM_CS'(1) << start_sel);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                div_d = div_q + 1'b1;
                if (tick) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (tick) begin
                    div_d   = '0;
                    sck_d   = ~sck_q;
                    phase_d = ~phase_q;
                    if (sample) begin
                        rx_d = {rx_q[DATA_W-2:0], miso};
                    end else if (bit_cnt_q != '0 || phase_q) begin
                        // CPHA=1 keeps the SETUP bit through the first leading edge
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[MAX_N-2];
                    end
                    if (phase_q) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == n_q - CNT_W'(1)) state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                div_d = div_q + 1'b1;
                if (tick) begin
                    div_d   = '0;
                    state_d = IDLE;
                    cs_n_d  = '1;
                    dout_d  = rx_q;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            addr_en_q <= 1'b0;
            cs_sel_q  <= '0;
            clkdiv_q  <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            n_q       <= '0;
            phase_q   <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            addr_en_q <= addr_en_d;
            cs_sel_q  <= cs_sel_d;
            clkdiv_q  <= clkdiv_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            err_q     <= err_d;
            irq_en_q  <= irq_en_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            n_q       <= n_d;
            phase_q   <= phase_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.read_data = rdata_q;
    assign sck           = sck_q;
    assign cs_n          = cs_n_q;
    assign mosi          = mosi_q;

`ifdef SPI_CTRL_IRQ_EN
    assign irq = done_q & irq_en_q;
`else
    assign irq = 1'b0;
`endif
endmodule
